// File: rtl/tft_lcd_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tft_lcd_pkg
// Brief    : Shared types and constants for the TFT LCD serial driver.
//            Macro TFT_LCD_9BIT_EN widens each word to D/C bit + 8 data bits.
// Revision : 1.0 - initial release
// ============================================================================
package tft_lcd_pkg;

    localparam int C_CLK_DIV_DEFAULT = 2;

`ifdef TFT_LCD_9BIT_EN
    localparam int C_WORD_W = 9;
`else
    localparam int C_WORD_W = 8;
`endif

    localparam int C_BIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tft_lcd_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : tft_lcd_driver_if
// Brief    : Sequencer-side request bus and LCD pad signals of the driver.
//            Macro TFT_LCD_9BIT_EN adds the dc_i word-type bit.
// Revision : 1.0 - initial release
// ============================================================================
interface tft_lcd_driver_if;
    logic       en_i;
    logic [7:0] data_i;
    logic       stop_flag;
`ifdef TFT_LCD_9BIT_EN
    logic       dc_i;
`endif
    logic       lcd_cs_o;
    logic       lcd_scl_o;
    logic       lcd_sda_o;
    logic       byte_done_o;
    logic       busy_o;

    modport master (
        output en_i, data_i, stop_flag,
`ifdef TFT_LCD_9BIT_EN
        output dc_i,
`endif
        input  lcd_cs_o, lcd_scl_o, lcd_sda_o, byte_done_o, busy_o
    );

    modport slave (
        input  en_i, data_i, stop_flag,
`ifdef TFT_LCD_9BIT_EN
        input  dc_i,
`endif
        output lcd_cs_o, lcd_scl_o, lcd_sda_o, byte_done_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/tft_lcd_driver_clkgen.sv
`default_nettype none
// ============================================================================
// Module   : tft_spi_clkgen
// Brief    : Half-period counter; o_tick marks the last cycle of each SCL phase.
// Revision : 1.0 - initial release
// ============================================================================
module tft_spi_clkgen
    import tft_lcd_pkg::*;
#(
    parameter int CLK_DIV = C_CLK_DIV_DEFAULT
) (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  i_en,
    output logic o_tick
);
    localparam int C_CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(CLK_DIV - 1);

    logic [C_CNT_W-1:0] r_cnt;

    // Held at zero while disabled so the first phase after start is full length.
    assign o_tick = i_en && (r_cnt == C_CNT_MAX);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_cnt <= '0;
        end else if (!i_en || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/tft_lcd_driver.sv
`default_nettype none
// ============================================================================
// Module   : tft_lcd_driver
// Brief    : SPI mode-0 write-only transmitter for a TFT LCD command/data port.
//            Macro TFT_LCD_9BIT_EN sends a D/C bit ahead of each data byte.
// Revision : 1.0 - initial release
// ============================================================================
module tft_lcd_driver
    import tft_lcd_pkg::*;
#(
    parameter int CLK_DIV = C_CLK_DIV_DEFAULT
) (
    input  wire             clk,
    input  wire             rst_n,
    tft_lcd_driver_if.slave bus
);
    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [C_WORD_W-1:0]     r_shreg;
    logic [C_BIT_CNT_W-1:0]  r_bit_cnt;
    logic                    r_phase;
    logic                    w_tick;
    logic                    w_last_bit;
    logic                    w_boundary;
    logic                    w_continue;
    logic [C_WORD_W-1:0]     w_load_word;

`ifdef TFT_LCD_9BIT_EN
    assign w_load_word = {bus.dc_i, bus.data_i};
`else
    assign w_load_word = bus.data_i;
`endif

    tft_spi_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (r_state != IDLE),
        .o_tick (w_tick)
    );

    assign w_last_bit = (r_bit_cnt == C_BIT_CNT_W'(C_WORD_W - 1));
    assign w_boundary = (r_state == SHIFT) && r_phase && w_tick && w_last_bit;
    assign w_continue = bus.en_i && !bus.stop_flag;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.en_i)                 w_state_nxt = SHIFT;
            SHIFT:   if (w_boundary && !w_continue) w_state_nxt = HOLD;
            HOLD:    if (w_tick)                   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Shift register, bit counter and SCL phase; r_phase=1 is the SCL-high half.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_phase   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.en_i) begin
                        r_shreg   <= w_load_word;
                        r_bit_cnt <= '0;
                        r_phase   <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (w_tick) begin
                        if (!r_phase) begin
                            r_phase <= 1'b1;
                        end else begin
                            r_phase <= 1'b0;
                            if (w_last_bit) begin
                                r_bit_cnt <= '0;
                                if (w_continue) begin
                                    r_shreg <= w_load_word;
                                end
                            end else begin
                                r_shreg   <= {r_shreg[C_WORD_W-2:0], 1'b0};
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.lcd_cs_o    = 1'b1;
        bus.lcd_scl_o   = 1'b0;
        bus.lcd_sda_o   = 1'b0;
        bus.byte_done_o = 1'b0;
        bus.busy_o      = 1'b0;
        case (r_state)
            SHIFT: begin
                bus.lcd_cs_o    = 1'b0;
                bus.lcd_scl_o   = r_phase;
                bus.lcd_sda_o   = r_shreg[C_WORD_W-1];
                bus.byte_done_o = w_boundary;
                bus.busy_o      = 1'b1;
            end
            HOLD: begin
                bus.lcd_cs_o = 1'b0;
                bus.busy_o   = 1'b1;
            end
            default: ;
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_tft_lcd_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_tft_lcd_driver
// Brief    : Directed self-checking bench for tft_lcd_driver (CLK_DIV = 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tft_lcd_driver;
    localparam int C_DIV = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    tft_lcd_driver_if bus ();

    tft_lcd_driver #(
        .CLK_DIV (C_DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Pad-side monitor state, updated on every falling edge.
    int         cyc = 0;
    int         rises, rx_n, done_cnt, viol;
    int         t_cs_fall, t_cs_rise, t_first_rise, t_last_fall;
    logic [7:0] rx_sh;
    logic [7:0] rx_q[$];
    int         done_t[$];
    logic       prev_cs  = 1'b1;
    logic       prev_scl = 1'b0;
    logic       prev_sda = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        rises = 0; rx_n = 0; done_cnt = 0; viol = 0; rx_sh = 8'h00;
        t_cs_fall = -1; t_cs_rise = -1; t_first_rise = -1; t_last_fall = -1;
        rx_q.delete();
        done_t.delete();
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input int n, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (done_cnt >= n) break;
            tick();
        end
        check_eq("byte_done_reached", done_cnt, n);
    endtask

    task automatic wait_cs_high(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (bus.lcd_cs_o === 1'b1) break;
            tick();
        end
        check_eq("cs_returns_high", bus.lcd_cs_o, 1);
    endtask

    initial begin
        clear_mon();
        forever begin
            @(negedge clk);
            cyc++;
            if (prev_cs && !bus.lcd_cs_o) t_cs_fall = cyc;
            if (!prev_cs && bus.lcd_cs_o) t_cs_rise = cyc;
            if (bus.lcd_scl_o && !prev_scl) begin
                rises++;
                if (t_first_rise < 0) t_first_rise = cyc;
                rx_sh = {rx_sh[6:0], bus.lcd_sda_o};
                rx_n++;
                if (rx_n == 8) begin
                    rx_q.push_back(rx_sh);
                    rx_n = 0;
                end
            end
            if (!bus.lcd_scl_o && prev_scl) t_last_fall = cyc;
            if (bus.lcd_scl_o && prev_scl && (bus.lcd_sda_o != prev_sda)) viol++;
            if (bus.byte_done_o) begin
                done_cnt++;
                done_t.push_back(cyc);
            end
            prev_cs  = bus.lcd_cs_o;
            prev_scl = bus.lcd_scl_o;
            prev_sda = bus.lcd_sda_o;
        end
    end

    initial begin
        bus.en_i      = 1'b0;
        bus.data_i    = 8'h00;
        bus.stop_flag = 1'b0;
        #1 rst_n = 1'b1;

        // Reset held for three cycles: pads idle, not busy.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("reset_idle", {bus.lcd_cs_o, bus.lcd_scl_o, bus.lcd_sda_o,
                                    bus.busy_o, bus.byte_done_o}, 5'b10000);
        end
        rst_n = 1'b0;
        tick(2);

        // Single byte 0xAA with stop_flag set.
        clear_mon();
        bus.data_i = 8'hAA; bus.en_i = 1'b1; bus.stop_flag = 1'b1;
        tick();
        check_eq("single_cs_low_1cyc", bus.lcd_cs_o, 0);
        check_eq("single_busy", bus.busy_o, 1);
        bus.en_i = 1'b0;
        wait_cs_high(60);
        check_eq("single_nbytes", rx_q.size(), 1);
        check_eq("single_data", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'hAA);
        check_eq("single_scl_rises", rises, 8);
        check_eq("single_done_pulses", done_cnt, 1);
        check_eq("single_cs_to_scl", t_first_rise - t_cs_fall, C_DIV);
        check_eq("single_scl_to_cs", t_cs_rise - t_last_fall, C_DIV);
        check_eq("single_cs_low_span", t_cs_rise - t_cs_fall, 16 * C_DIV + C_DIV);
        check_eq("single_sda_stable", viol, 0);
        tick();
        check_eq("single_idle_busy", bus.busy_o, 0);

        // Continuous frame: AA, AA (stop pulsed mid-byte, data changed), 3C, then stop.
        clear_mon();
        bus.data_i = 8'hAA; bus.en_i = 1'b1; bus.stop_flag = 1'b0;
        wait_done(1, 60);
        tick(13);
        bus.stop_flag = 1'b1;
        tick(2);
        bus.stop_flag = 1'b0;
        bus.data_i    = 8'h3C;
        wait_done(2, 60);
        tick();
        bus.stop_flag = 1'b1;
        wait_done(3, 60);
        bus.en_i = 1'b0;
        wait_cs_high(20);
        bus.stop_flag = 1'b0;
        check_eq("cont_nbytes", rx_q.size(), 3);
        check_eq("cont_byte0", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'hAA);
        check_eq("cont_byte1", (rx_q.size() > 1) ? rx_q[1] : 8'hxx, 8'hAA);
        check_eq("cont_byte2", (rx_q.size() > 2) ? rx_q[2] : 8'hxx, 8'h3C);
        check_eq("cont_done_gap0", (done_t.size() > 1) ? done_t[1] - done_t[0] : -1, 16 * C_DIV);
        check_eq("cont_done_gap1", (done_t.size() > 2) ? done_t[2] - done_t[1] : -1, 16 * C_DIV);
        check_eq("cont_cs_low_span", t_cs_rise - t_cs_fall, 3 * 16 * C_DIV + C_DIV);
        check_eq("cont_scl_rises", rises, 24);
        check_eq("cont_sda_stable", viol, 0);

        // Reset during bit 3 of 0xC3, then a fresh 0x96 frame.
        tick(2);
        clear_mon();
        bus.data_i = 8'hC3; bus.en_i = 1'b1; bus.stop_flag = 1'b1;
        tick();
        check_eq("rstmid_cs_low", bus.lcd_cs_o, 0);
        tick(17);
        check_eq("rstmid_bits_before", rises, 4);
        rst_n = 1'b1;
        #1;
        check_eq("rstmid_pads_idle", {bus.lcd_cs_o, bus.lcd_scl_o, bus.lcd_sda_o,
                                      bus.busy_o, bus.byte_done_o}, 5'b10000);
        tick();
        rst_n = 1'b0;
        clear_mon();
        bus.data_i = 8'h96;
        tick();
        check_eq("rstmid_restart_cs", bus.lcd_cs_o, 0);
        bus.en_i = 1'b0;
        wait_cs_high(60);
        check_eq("rstmid_nbytes", rx_q.size(), 1);
        check_eq("rstmid_data", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h96);
        check_eq("rstmid_scl_rises", rises, 8);
        check_eq("rstmid_cs_to_scl", t_first_rise - t_cs_fall, C_DIV);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/tft_lcd_driver.md
# tft_lcd_driver

Write-only serial (SPI mode 0) transmitter for a TFT LCD controller's command/data port. Takes parallel bytes from the display-control logic and shifts them MSB-first onto the chip-select / serial-clock / serial-data pins. Sits between the LCD init/pixel sequencer and the FPGA I/O pads. Supports continuous back-to-back bytes under one chip-select frame.

## Interface
- `CLK_DIV`, default 2: system clocks per SCL half-period, ≥1.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-high reset (asserted = 1) despite the name.
- `en_i` in 1: transfer request, level-sensitive.
- `data_i` in 8: byte to send; latched at frame start and at each byte boundary.
- `stop_flag` in 1: end the frame after the current byte.
- `lcd_cs_o` out 1: chip select, active low.
- `lcd_scl_o` out 1: serial clock, idles low.
- `lcd_sda_o` out 1: serial data, MSB first.
- `byte_done_o` out 1: one-cycle pulse when a byte's last SCL high phase ends.
- `busy_o` out 1: high whenever not IDLE.

## Operation
- States: IDLE, SHIFT, HOLD.
- IDLE: cs=1, scl=0, sda=0. If en_i=1, latch data_i into an 8-bit shift register, clear the bit counter, drive cs=0, and go to SHIFT.
- SHIFT: each bit has a low phase followed by a high phase.
  - Low phase: scl=0 for CLK_DIV cycles, sda = current MSB.
  - High phase: scl=1 for CLK_DIV cycles, sda stable.
  - After the high phase, shift left and increment the counter.
- Byte boundary (end of bit 0's high phase): pulse byte_done_o. Then sample en_i and stop_flag:
  - en_i=1 and stop_flag=0: latch the new data_i and start bit 7 immediately (no gap, cs stays 0).
  - Otherwise: go to HOLD.
- HOLD: scl=0, cs=0 for CLK_DIV cycles, then cs=1 and go to IDLE.
- stop_flag and en_i are ignored mid-byte; a byte in flight always completes.
- Reset: all outputs to idle values immediately (cs=1, scl=0, sda=0, byte_done_o=0, busy_o=0). Any in-flight byte is discarded.

## Timing
- en_i rise to cs fall: 1 cycle.
- cs fall to first scl rise: CLK_DIV cycles.
- Bit period: 2·CLK_DIV cycles. Byte: 16·CLK_DIV cycles.
- Last scl fall to cs rise: CLK_DIV cycles.
- Minimum cs-high time between frames: 1 cycle (IDLE).
- sda changes only while scl=0 (on the scl fall or at frame start), so it is stable on every scl rise.
- CLK_DIV=2 at 100 MHz gives a 25 MHz SCL.

## Configuration
- `TFT_LCD_9BIT_EN` defined: adds input `dc_i` (1 bit), latched together with data_i. Each word is 9 bits: the D/C bit first, then data bits 7..0. Byte time becomes 18·CLK_DIV cycles, and the counter runs 0..8.
- Undefined: 8-bit frames only, and no dc_i port exists.

## Structure
- Shared package `tft_lcd_pkg`: state enum (IDLE/SHIFT/HOLD), the `CLK_DIV` default constant, and the word-width constant (8, or 9 under the macro).
- One natural sub-module: `tft_spi_clkgen`, a half-period counter that emits phase-toggle strobes; the FSM and shift register stay in the top.

## Test plan
- Reset: hold rst_n=1 for 3 cycles → cs=1, scl=0, sda=0, busy_o=0 throughout.
- Single byte: data_i=0xAA, en_i=1 at t=20 ns, stop_flag=1 → cs low after 1 cycle. Eight scl pulses with sda sampled at the rises = 1,0,1,0,1,0,1,0; one byte_done_o pulse; cs high CLK_DIV cycles after the last scl fall.
- Continuous: data_i=0xAA, en_i held 1, stop_flag=0 → cs stays low, sda repeats 10101010 with no scl gap, byte_done_o every 16·CLK_DIV cycles.
- Mid-byte stop: stop_flag pulsed during bit 4 → ignored; with stop_flag=1 held to the boundary, exactly one 0xAA frame.
- Byte change: data_i switched 0xAA→0x3C mid-byte → current byte stays 0xAA, next byte 0x3C (00111100).
- Reset mid-byte: rst_n=1 during bit 3 → cs=1, scl=0 the same cycle; after release with en_i=1, a fresh full byte starting at bit 7.
